// File: rtl/data_memory.sv
// data_memory: DEPTH x 32-bit word memory, combinational read, async-cleared storage.
// Define DATA_MEMORY_ADDR_ERR_EN to add the addr_err out-of-range flag.
module data_memory #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] read_data
`ifdef DATA_MEMORY_ADDR_ERR_EN
   ,
   output logic        addr_err
`endif
);
   logic [31:0] mem_q [DEPTH];
   logic        in_range;
   assign in_range = (address >> AW) == 32'd0;
   // An X/Z enable fails the if-test, so an undriven mem_write never writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_write && in_range) begin
         mem_q[address[AW-1:0]] <= write_data;
      end
   end
   assign read_data = (rst_n && mem_read && in_range) ? mem_q[address[AW-1:0]] : 32'h0;
`ifdef DATA_MEMORY_ADDR_ERR_EN
   assign addr_err = rst_n && (mem_read || mem_write) && !in_range;
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vectors for data_memory; a queue-based scoreboard decouples stimulus from checking.
module tb_data_memory;
   localparam int DEPTH = 256;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] read_data;
`ifdef DATA_MEMORY_ADDR_ERR_EN
   logic        addr_err;
`endif
   typedef struct {
      string       name;
      logic [31:0] exp;
      bit          err;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   event mon_ev;
   int   checks = 0;
   int   failures = 0;

   data_memory #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .address(address),
      .write_data(write_data),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .read_data(read_data)
`ifdef DATA_MEMORY_ADDR_ERR_EN
      ,
      .addr_err(addr_err)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: drains every expectation queued for the current sample point.
   always begin
      @(mon_ev);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
`ifdef DATA_MEMORY_ADDR_ERR_EN
         if (e.err) begin
            if (addr_err !== e.exp[0]) begin
               failures++;
               $display("FAIL %s: addr_err=%b expected=%b", e.name, addr_err, e.exp[0]);
            end
         end else
`endif
         if (read_data !== e.exp) begin
            failures++;
            $display("FAIL %s: read_data=%h expected=%h", e.name, read_data, e.exp);
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] x, input bit err = 1'b0);
      #1;
      sb.push_back('{n, x, err});
      -> mon_ev;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      mem_read = 1'b1;
      chk("rst_hold_read", 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         address = i;
         chk($sformatf("reset_rd%0d", i), 32'h0);
      end
      mem_read = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         address = i;
         write_data = i;
         mem_write = 1'b1;
         @(posedge clk);
      end
      @(negedge clk) mem_write = 1'b0;
      mem_read = 1'b1;
      for (int i = 0; i < 30; i++) begin
         address = i;
         chk($sformatf("readback%0d", i), i);
         #3;
      end
      mem_read = 1'b0;
      address = 5;
      chk("read_disabled", 32'h0);
`ifdef DATA_MEMORY_ADDR_ERR_EN
      mem_read = 1'b1;
      chk("addr_err_inrange", 32'h0, 1'b1);
`endif
      @(negedge clk);
      address = DEPTH;
      write_data = 32'hDEAD_BEEF;
      mem_write = 1'b1;
      mem_read = 1'b1;
      chk("oor_read", 32'h0);
`ifdef DATA_MEMORY_ADDR_ERR_EN
      chk("addr_err_oor", 32'h1, 1'b1);
`endif
      @(posedge clk);
      @(negedge clk) mem_write = 1'b0;
      address = 0;
      chk("oor_addr0_kept", 32'h0);
      address = DEPTH + 5;
      chk("oor_alias_read", 32'h0);
      address = 29;
      chk("oor_addr29_kept", 32'd29);
      @(negedge clk);
      address = 7;
      write_data = 32'hA5A5_A5A5;
      mem_write = 1'b1;
      chk("rdw_before_edge", 32'd7);
      @(posedge clk);
      chk("rdw_after_edge", 32'hA5A5_A5A5);
      @(negedge clk);
      mem_write = 1'b0;
      address = 10;
      write_data = 32'h0000_1234;
      mem_write = 1'b1;
      #2 rst_n = 1'b0;
      chk("async_rst_read", 32'h0);
`ifdef DATA_MEMORY_ADDR_ERR_EN
      address = DEPTH;
      chk("addr_err_in_reset", 32'h0, 1'b1);
      address = 10;
`endif
      @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         address = i;
         chk($sformatf("post_rst_rd%0d", i), 32'h0);
      end
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      address = 3;
      write_data = 32'h0000_0033;
      mem_write = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      chk("first_write_after_rst", 32'h0000_0033);
      @(negedge clk) mem_write = 1'b0;
      address = 4;
      chk("neighbour_untouched", 32'h0);
      #5;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
